fp_operand_unpacker: RTL and testbench

Parametrised, pipelined operand unpacker for the FPU. Splits an IEEE-754-style word into sign, unbiased exponent and mantissa with explicit hidden bit. Classifies special values and, in square-root mode, pre-adjusts the exponent to even parity. It sits between operand issue and the sqrt/arithmetic datapaths, with a one-cycle registered output and a two-entry skid buffer for valid/ready backpressure.

---
 rtl/fp_unpack_pkg.sv | 26 ++
 rtl/fp_lzc.sv | 20 ++
 rtl/fp_operand_unpacker.sv | 166 ++++++++++++++++
 tb/tb_fp_operand_unpacker.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_unpack_pkg.sv
// Shared constants and width helpers for the FP operand unpacker.
// Class vector is one-hot {nan, inf, subnormal, zero, normal}, indexed by CLS_*.
package fp_unpack_pkg;

    localparam int CLS_NORMAL    = 0;
    localparam int CLS_ZERO      = 1;
    localparam int CLS_SUBNORMAL = 2;
    localparam int CLS_INF       = 3;
    localparam int CLS_NAN       = 4;
    localparam int CLS_W         = 5;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Unbiased exponent is signed and must also hold the normalised-subnormal range.
    function automatic int fp_exp_out_w(input int exp_w);
        return exp_w + 2;
    endfunction

    // Two integer bits: hidden bit plus headroom for the sqrt parity shift.
    function automatic int fp_man_out_w(input int man_w);
        return man_w + 2;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
    parameter int WIDTH = 23,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] count
);

    // Scan upward so the highest set bit is the last one to write the count.
    always_comb begin
        count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (data[i]) begin
                count = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_operand_unpacker.sv
// Splits an IEEE-754-style word into sign / unbiased exponent / mantissa with hidden bit,
// classifies it, applies sqrt exponent parity, and registers it behind a two-entry skid.
// FP_UNPACK_SUBNORM_NORM_EN: normalise subnormals (default build flushes them to zero).
module fp_operand_unpacker
    import fp_unpack_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [EXP_W+MAN_W:0]              in_data,
    input  logic                              in_sqrt_mode,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_sign,
    output logic [fp_exp_out_w(EXP_W)-1:0]    out_exp,
    output logic [fp_man_out_w(MAN_W)-1:0]    out_man,
    output logic [CLS_W-1:0]                  out_class,
    output logic                              out_invalid
);

    localparam int XW = fp_exp_out_w(EXP_W);
    localparam int MW = fp_man_out_w(MAN_W);
    localparam logic [XW-1:0] BIAS_X = XW'(fp_bias(EXP_W));

    logic             sgn;
    logic [EXP_W-1:0] e_fld;
    logic [MAN_W-1:0] f_fld;
    logic             e_max;
    logic             e_min;
    logic             f_nz;

    assign sgn   = in_data[EXP_W+MAN_W];
    assign e_fld = in_data[MAN_W +: EXP_W];
    assign f_fld = in_data[MAN_W-1:0];
    assign e_max = &e_fld;
    assign e_min = ~|e_fld;
    assign f_nz  = |f_fld;

`ifdef FP_UNPACK_SUBNORM_NORM_EN
    localparam int LZ_W = $clog2(MAN_W + 1);

    logic [LZ_W-1:0] lz;
    logic [LZ_W:0]   sub_shamt;
    logic [MW-1:0]   sub_man;
    logic [XW-1:0]   sub_exp;

    fp_lzc #(
        .WIDTH (MAN_W)
    ) u_lzc (
        .data  (f_fld),
        .count (lz)
    );

    // exp = 1 - BIAS - (lz + 1) simplifies to -BIAS - lz.
    assign sub_shamt = {1'b0, lz} + (LZ_W + 1)'(1);
    assign sub_man   = {2'b00, f_fld} << sub_shamt;
    assign sub_exp   = XW'(0) - BIAS_X - XW'(lz);
`endif

    logic [XW-1:0]    u_exp;
    logic [MW-1:0]    u_man;
    logic [CLS_W-1:0] u_cls;
    logic             u_inv;

    always_comb begin
        u_exp = '0;
        u_man = '0;
        u_cls = '0;
        if (e_max) begin
            if (f_nz) begin
                u_cls[CLS_NAN] = 1'b1;
                u_man          = {2'b01, f_fld};
            end else begin
                u_cls[CLS_INF] = 1'b1;
            end
        end else if (e_min) begin
            if (!f_nz) begin
                u_cls[CLS_ZERO] = 1'b1;
            end else begin
`ifdef FP_UNPACK_SUBNORM_NORM_EN
                u_cls[CLS_SUBNORMAL] = 1'b1;
                u_exp                = sub_exp;
                u_man                = sub_man;
`else
                u_cls[CLS_ZERO] = 1'b1;
`endif
            end
        end else begin
            u_cls[CLS_NORMAL] = 1'b1;
            u_exp             = {2'b00, e_fld} - BIAS_X;
            u_man             = {2'b01, f_fld};
        end

        // Sqrt wants an even exponent: fold an odd one into the mantissa ([2,4) range).
        if (in_sqrt_mode && (u_cls[CLS_NORMAL] || u_cls[CLS_SUBNORMAL]) && u_exp[0]) begin
            u_man = u_man << 1;
            u_exp = u_exp - XW'(1);
        end

        u_inv = in_sqrt_mode && sgn &&
                (u_cls[CLS_NORMAL] || u_cls[CLS_SUBNORMAL] || u_cls[CLS_INF]);
    end

    logic             skid_valid;
    logic             s_sign;
    logic [XW-1:0]    s_exp;
    logic [MW-1:0]    s_man;
    logic [CLS_W-1:0] s_cls;
    logic             s_inv;
    logic             accept;
    logic             out_free;

    // in_ready is a pure register output; out_ready never reaches it combinationally.
    assign in_ready = ~skid_valid;
    assign accept   = in_valid && ~skid_valid;
    assign out_free = ~out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_sign    <= 1'b0;
            out_exp     <= '0;
            out_man     <= '0;
            out_class   <= '0;
            out_invalid <= 1'b0;
            skid_valid  <= 1'b0;
            s_sign      <= 1'b0;
            s_exp       <= '0;
            s_man       <= '0;
            s_cls       <= '0;
            s_inv       <= 1'b0;
        end else if (out_free) begin
            // A full skid always drains first; input is blocked while it is full.
            if (skid_valid) begin
                out_valid   <= 1'b1;
                out_sign    <= s_sign;
                out_exp     <= s_exp;
                out_man     <= s_man;
                out_class   <= s_cls;
                out_invalid <= s_inv;
                skid_valid  <= 1'b0;
            end else if (accept) begin
                out_valid   <= 1'b1;
                out_sign    <= sgn;
                out_exp     <= u_exp;
                out_man     <= u_man;
                out_class   <= u_cls;
                out_invalid <= u_inv;
            end else begin
                out_valid   <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            s_sign     <= sgn;
            s_exp      <= u_exp;
            s_man      <= u_man;
            s_cls      <= u_cls;
            s_inv      <= u_inv;
        end
    end

endmodule

// File: tb/tb_fp_operand_unpacker.sv
// Self-checking bench for fp_operand_unpacker (EXP_W=8, MAN_W=23) with a value-level reference model.
module tb_fp_operand_unpacker;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_sqrt_mode;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [9:0]  out_exp;
    logic [24:0] out_man;
    logic [4:0]  out_class;
    logic        out_invalid;

    int errors = 0;
    int checks = 0;
    int acc_count = 0;

    typedef struct packed {
        logic        sign;
        logic [9:0]  exp;
        logic [24:0] man;
        logic [4:0]  cls;
        logic        inv;
    } rec_t;

    rec_t exp_q[$];
    rec_t got_q[$];

    fp_operand_unpacker #(.EXP_W(8), .MAN_W(23)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_sqrt_mode (in_sqrt_mode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sign     (out_sign),
        .out_exp      (out_exp),
        .out_man      (out_man),
        .out_class    (out_class),
        .out_invalid  (out_invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Value-level model: mantissa * 2^(exp - 23) reproduces the input value.
    function automatic rec_t model(input logic [31:0] w, input logic sq);
        rec_t   r;
        int     e;
        int     f;
        int     x;
        longint m;
        r = '0;
        r.sign = w[31];
        e = int'(w[30:23]);
        f = int'(w[22:0]);
        x = 0;
        m = 0;
        if (e == 255) begin
            if (f != 0) begin
                r.cls = 5'b10000;
                m = longint'(f) + (64'd1 << 23);
            end else begin
                r.cls = 5'b01000;
            end
        end else if (e == 0) begin
            if (f == 0) begin
                r.cls = 5'b00010;
            end else begin
`ifdef FP_UNPACK_SUBNORM_NORM_EN
                r.cls = 5'b00100;
                m = longint'(f);
                x = -126;
                while (m < (64'd1 << 23)) begin
                    m = m * 2;
                    x = x - 1;
                end
`else
                r.cls = 5'b00010;
`endif
            end
        end else begin
            r.cls = 5'b00001;
            x = e - 127;
            m = longint'(f) + (64'd1 << 23);
        end
        if (sq && (r.cls == 5'b00001 || r.cls == 5'b00100) && (x % 2 != 0)) begin
            m = m * 2;
            x = x - 1;
        end
        r.inv = sq && w[31] && (r.cls == 5'b00001 || r.cls == 5'b00100 || r.cls == 5'b01000);
        r.exp = 10'(x);
        r.man = 25'(m);
        return r;
    endfunction

    // One clock of bookkeeping: records accepted inputs (as model output) and delivered outputs.
    task automatic step();
        rec_t g;
        logic acc;
        logic fire;
        acc  = in_valid && in_ready;
        fire = out_valid && out_ready;
        if (fire) begin
            g.sign = out_sign;
            g.exp  = out_exp;
            g.man  = out_man;
            g.cls  = out_class;
            g.inv  = out_invalid;
            got_q.push_back(g);
        end
        if (acc) begin
            exp_q.push_back(model(in_data, in_sqrt_mode));
            acc_count++;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_word();
        logic [7:0]  e;
        logic [22:0] f;
        case ($urandom_range(0, 5))
            0:       e = 8'd0;
            1:       e = 8'd255;
            2:       e = ($urandom_range(0, 1) != 0) ? 8'd1 : 8'd254;
            default: e = 8'($urandom);
        endcase
        case ($urandom_range(0, 3))
            0:       f = '0;
            1:       f = 23'(1) << $urandom_range(0, 22);
            default: f = 23'($urandom);
        endcase
        return {1'($urandom), e, f};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 32'h4049_0FDB;
        in_sqrt_mode = 1'b1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++;
        if ({out_sign, out_exp, out_man, out_class, out_invalid} !== '0) begin
            errors++;
            $display("FAIL reset_data got=%b/%h/%h/%b/%b want=all zero",
                     out_sign, out_exp, out_man, out_class, out_invalid);
        end
    endtask

    localparam int NDIR = 10;
    logic [31:0] dir_w  [NDIR] = '{32'h3F80_0000, 32'h4000_0000, 32'h4080_0000, 32'h0000_0001,
                                   32'h7FC0_0000, 32'hFF80_0000, 32'hC080_0000, 32'h8000_0000,
                                   32'h3F00_0000, 32'h8000_0001};
    logic        dir_sq [NDIR] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`ifdef FP_UNPACK_SUBNORM_NORM_EN
    int          dir_x  [NDIR] = '{0, 0, 2, -149, 0, 0, 2, 0, -2, -150};
    logic [24:0] dir_m  [NDIR] = '{25'h080_0000, 25'h100_0000, 25'h080_0000, 25'h080_0000, 25'h0C0_0000,
                                   25'h0, 25'h080_0000, 25'h0, 25'h100_0000, 25'h100_0000};
    logic [4:0]  dir_c  [NDIR] = '{5'b00001, 5'b00001, 5'b00001, 5'b00100, 5'b10000,
                                   5'b01000, 5'b00001, 5'b00010, 5'b00001, 5'b00100};
    logic        dir_i  [NDIR] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
`else
    int          dir_x  [NDIR] = '{0, 0, 2, 0, 0, 0, 2, 0, -2, 0};
    logic [24:0] dir_m  [NDIR] = '{25'h080_0000, 25'h100_0000, 25'h080_0000, 25'h0, 25'h0C0_0000,
                                   25'h0, 25'h080_0000, 25'h0, 25'h100_0000, 25'h0};
    logic [4:0]  dir_c  [NDIR] = '{5'b00001, 5'b00001, 5'b00001, 5'b00010, 5'b10000,
                                   5'b01000, 5'b00001, 5'b00010, 5'b00001, 5'b00010};
    logic        dir_i  [NDIR] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`endif

    task automatic test_directed();
        for (int i = 0; i < NDIR; i++) begin
            out_ready = 1'b1;
            in_valid = 1'b1;
            in_data = dir_w[i];
            in_sqrt_mode = dir_sq[i];
            step();
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL dir%0d_latency out_valid got=%b want=1", i, out_valid);
            end
            checks++;
            if ({out_sign, out_exp, out_man, out_class, out_invalid} !==
                {dir_w[i][31], 10'(dir_x[i]), dir_m[i], dir_c[i], dir_i[i]}) begin
                errors++;
                $display("FAIL dir%0d_%h got s=%b e=%0d m=%h c=%b i=%b want s=%b e=%0d m=%h c=%b i=%b",
                         i, dir_w[i], out_sign, $signed(out_exp), out_man, out_class, out_invalid,
                         dir_w[i][31], dir_x[i], dir_m[i], dir_c[i], dir_i[i]);
            end
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_drain out_valid got=%b want=0", i, out_valid);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_backpressure();
        logic [31:0] w [3];
        rec_t        snap;
        rec_t        m;
        int          n;
        for (int i = 0; i < 3; i++) w[i] = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
        exp_q.delete();
        got_q.delete();
        acc_count = 0;
        out_ready = 1'b0;
        in_sqrt_mode = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = w[i];
            if (i == 2) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_third_in_ready got=%b want=0", in_ready);
                end
            end
            step();
            if (i == 0) snap = {out_sign, out_exp, out_man, out_class, out_invalid};
        end
        step();
        checks++;
        if (acc_count !== 2) begin errors++; $display("FAIL bp_accepted got=%0d want=2", acc_count); end
        checks++;
        if (out_valid !== 1'b1 || {out_sign, out_exp, out_man, out_class, out_invalid} !== snap) begin
            errors++;
            $display("FAIL bp_hold_stable got v=%b %h want v=1 %h", out_valid,
                     {out_sign, out_exp, out_man, out_class, out_invalid}, snap);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_rise got=%b want=1", in_ready); end
        n = 0;
        while (acc_count < 3 && n < 5) begin step(); n++; end
        in_valid = 1'b0;
        n = 0;
        while (got_q.size() < 3 && n < 8) begin step(); n++; end
        step();
        checks++;
        if (got_q.size() !== 3) begin
            errors++;
            $display("FAIL bp_count got=%0d want=3", got_q.size());
        end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            m = model(w[i], 1'b0);
            checks++;
            if (got_q[i] !== m) begin
                errors++;
                $display("FAIL bp_order%0d got=%h want=%h", i, got_q[i], m);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_random();
        int   n;
        rec_t g;
        rec_t x;
        exp_q.delete();
        got_q.delete();
        for (int c = 0; c < 600; c++) begin
            in_valid     = ($urandom_range(0, 3) != 0);
            in_data      = rand_word();
            in_sqrt_mode = 1'($urandom);
            out_ready    = ($urandom_range(0, 9) < 7);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (got_q.size() < exp_q.size() && n < 10) begin step(); n++; end
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL rand_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            x = exp_q.pop_front();
            checks++;
            if (g !== x) begin
                errors++;
                $display("FAIL rand_item got s=%b e=%0d m=%h c=%b i=%b want s=%b e=%0d m=%h c=%b i=%b",
                         g.sign, $signed(g.exp), g.man, g.cls, g.inv,
                         x.sign, $signed(x.exp), x.man, x.cls, x.inv);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [31:0] fresh;
        rec_t        m;
        int          n;
        exp_q.delete();
        got_q.delete();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_sqrt_mode = 1'b0;
        in_data = 32'h4120_0000;
        step();
        in_data = 32'hC2C8_0000;
        step();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rmid_full got in_ready=%b out_valid=%b want 0/1", in_ready, out_valid);
        end
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rmid_after_rst got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        exp_q.delete();
        got_q.delete();
        repeat (3) step();
        checks++;
        if (got_q.size() !== 0) begin
            errors++;
            $display("FAIL rmid_stale got=%0d outputs want=0", got_q.size());
        end
        fresh = 32'h3FC0_0000;
        in_valid = 1'b1;
        in_data = fresh;
        step();
        in_valid = 1'b0;
        n = 0;
        while (got_q.size() < 1 && n < 5) begin step(); n++; end
        m = model(fresh, 1'b0);
        checks++;
        if (got_q.size() !== 1 || got_q[0] !== m) begin
            errors++;
            $display("FAIL rmid_fresh got n=%0d first=%h want n=1 %h", got_q.size(),
                     (got_q.size() > 0) ? got_q[0] : rec_t'('0), m);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_sqrt_mode = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
